// File: rtl/pprm_pkg.sv
// Shared state encoding and inverse-affine helper for the byte-serial inverse S-box engine.
package pprm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    // rotl(s,1) ^ rotl(s,3) ^ rotl(s,6) ^ 0x05
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/pprm_inv_sbox.sv
// Single-byte inverse S-box: inverse affine followed by a GF(2^8) AND/XOR inverter.
// PPRM_INV_SBOX_PIPE_EN adds a register between the affine stage and the inverter.
module pprm_inv_sbox
    import pprm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 as a product of the seven squares x^2..x^128; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

`ifdef PPRM_INV_SBOX_PIPE_EN
    logic [7:0] r_x;
    logic       r_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_v <= 1'b0;
        end else begin
            r_x <= inv_affine(i_byte);
            r_v <= i_valid;
        end
    end

    assign o_byte  = gf_inv(r_x);
    assign o_valid = r_v;
`else
    logic w_unused;
    assign w_unused = clk ^ reset_n;

    assign o_byte  = gf_inv(inv_affine(i_byte));
    assign o_valid = i_valid;
`endif

endmodule

// File: rtl/pprm_inv_subbytes_serial.sv
// Byte-serial AES InvSubBytes: loads a block, rewrites one byte per cycle, hands the block back.
// PPRM_INV_SBOX_PIPE_EN selects the pipelined inverse S-box (one extra RUN cycle).
module pprm_inv_subbytes_serial
    import pprm_pkg::*;
#(
    parameter int NBYTES = 16
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy
);

    localparam int              CW   = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);
    localparam logic [CW-1:0]   FULL = CW'(NBYTES);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [8*NBYTES-1:0] r_data;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic                w_rd_en;
    logic [7:0]          w_rd_byte;
    logic                w_sb_valid;
    logic [7:0]          w_wb_byte;
    logic                w_wr_en;
    logic [CW-1:0]       w_widx;

    assign w_rd_en = (r_state == RUN) && (r_cnt != FULL);
    assign w_wr_en = (r_state == RUN) && w_sb_valid;

    always_comb begin
        w_rd_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (r_cnt == CW'(i)) w_rd_byte = r_data[8*i +: 8];
        end
    end

    pprm_inv_sbox u_sbox (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_rd_en),
        .i_byte  (w_rd_byte),
        .o_valid (w_sb_valid),
        .o_byte  (w_wb_byte)
    );

`ifdef PPRM_INV_SBOX_PIPE_EN
    // Write-back index trails the read index by the one pipe stage.
    logic [CW-1:0] r_widx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_widx <= '0;
        else          r_widx <= r_cnt;
    end

    assign w_widx = r_widx;
`else
    assign w_widx = r_cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_rd_en) r_cnt <= r_cnt + 1'b1;
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (w_wr_en && (w_widx == CW'(i))) r_data[8*i +: 8] <= w_wb_byte;
                    end
                    if (w_wr_en && (w_widx == LAST)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_data;

endmodule

// File: tb/tb_pprm_inv_subbytes_serial.sv
// Directed self-checking bench for pprm_inv_subbytes_serial (either PPRM_INV_SBOX_PIPE_EN build).
module tb_pprm_inv_subbytes_serial;

    localparam int NB = 16;
`ifdef PPRM_INV_SBOX_PIPE_EN
    localparam int LAT = NB + 1;
`else
    localparam int LAT = NB;
`endif

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [8*NB-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [8*NB-1:0] out_data;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    pprm_inv_subbytes_serial #(.NBYTES(NB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_of(input logic [127:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = INV_SBOX[b[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Waits for in_ready, presents one block for a single accept edge, then waits for out_valid.
    task automatic run_block(input logic [127:0] blk, output logic [127:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_data  = blk;
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = out_data;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] blk;
        logic [127:0] expv;
        logic [127:0] b6 [3];
        int           lat;
        int           acc, got, c6, last_acc, extra;
        logic         acc_now;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_out_data",  out_data,  0);

        // all-zero block
        out_ready = 1'b1;
        run_block('0, res, lat);
        check("zero_latency", lat, LAT);
        check("zero_data", res, {16{8'h52}});
        check("zero_busy_done", busy, 1);
        check("zero_in_ready_done", in_ready, 0);
        tick();
        check("zero_out_valid_after", out_valid, 0);
        check("zero_in_ready_after", in_ready, 1);

        // known FIPS-197 pairs
        run_block({{12{8'h00}}, 8'h16, 8'hED, 8'h7C, 8'h63}, res, lat);
        check("pairs_latency", lat, LAT);
        check("pairs_data", res, {{12{8'h52}}, 8'hFF, 8'h53, 8'h01, 8'h00});

        // exhaustive over 0x00..0xFF
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < NB; i++) blk[8*i +: 8] = 8'(16*b + i);
            run_block(blk, res, lat);
            check("exhaustive_block", res, exp_of(blk));
        end
        tick();

        // backpressure in DONE
        out_ready = 1'b0;
        blk = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        expv = exp_of(blk);
        run_block(blk, res, lat);
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, expv);
            check("hold_in_ready", in_ready, 0);
            if (k == 1) begin
                in_valid = 1'b1;
                in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_data_kept", out_data, expv);

        // reset pulse mid-RUN at cnt=7
        in_valid = 1'b1;
        in_data  = 128'h11223344556677889900aabbccddeeff;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        blk = 128'h8040201008040201fedcba9876543210;
        run_block(blk, res, lat);
        check("post_abort_latency", lat, LAT);
        check("post_abort_data", res, exp_of(blk));
        repeat (2) tick();

        // back-to-back blocks
        b6[0] = 128'h000102030405060708090a0b0c0d0e0f;
        b6[1] = 128'hffeeddccbbaa99887766554433221100;
        b6[2] = 128'h5a5aa5a53c3cc3c30ff0f00f96696996;
        acc = 0; got = 0; c6 = 0; last_acc = 0;
        in_valid  = 1'b1;
        in_data   = b6[0];
        out_ready = 1'b1;
        while (got < 3 && c6 < 200) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                check("b2b_data", out_data, exp_of(b6[got]));
                got++;
            end
            if (acc_now && acc > 0) check("b2b_spacing", c6 - last_acc, LAT + 2);
            if (acc_now) begin
                last_acc = c6;
                acc++;
            end
            tick();
            c6++;
            if (acc_now) begin
                if (acc < 3) in_data = b6[acc];
                else begin
                    in_valid = 1'b0;
                    in_data  = rnd128();
                end
            end
        end
        check("b2b_results", got, 3);
        check("b2b_accepts", acc, 3);
        extra = 0;
        repeat (LAT + 4) begin
            if (out_valid) extra++;
            tick();
        end
        check("b2b_no_dup", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
